// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: definitions shared by the control sequencer and the datapath ALU decode.
//   - opcode constants (IR[31:27])
//   - sequencer state encoding T0..T6 plus HALTED
//   - opcode-class helpers is_alu / is_muldiv
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_SHR  = 5'b00101;
  localparam opcode_t OP_SHRA = 5'b00110;
  localparam opcode_t OP_SHL  = 5'b00111;
  localparam opcode_t OP_ROR  = 5'b01000;
  localparam opcode_t OP_ROL  = 5'b01001;
  localparam opcode_t OP_AND  = 5'b01010;
  localparam opcode_t OP_OR   = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01111;
  localparam opcode_t OP_DIV  = 5'b10000;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    S_T0     = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_T3     = 3'd3,
    S_T4     = 3'd4,
    S_T5     = 3'd5,
    S_T6     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  // Single-result register-register ops (writeback through Zlow -> Ra).
  function automatic logic is_alu(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
                      OP_ROR, OP_ROL, OP_AND, OP_OR};
  endfunction

  // Double-width result ops (Zlow -> LO, Zhigh -> HI).
  function automatic logic is_muldiv(input opcode_t op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_wait.sv
// alu_ctrl_seq_wait: memory-wait timeout counter for the fetch state T1.
//   clock   in  system clock
//   clear   in  async active-low reset
//   clr_cnt in  zero the counter (asserted in T0, so it is zero on entry to T1)
//   tick    in  one T1 cycle elapsed without mem_ready
//   expire  out this tick is the MEMW-th consecutive one (never when MEMW = 0)
module alu_ctrl_seq_wait #(
  parameter int MEMW = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic clr_cnt,
  input  logic tick,
  output logic expire
);

  localparam int CW = (MEMW > 0) ? $clog2(MEMW + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)       cnt <= '0;
    else if (clr_cnt) cnt <= '0;
    else if (tick)    cnt <= cnt + 1'b1;
  end

  // Count holds ticks already seen, so the MEMW-th idle cycle sees MEMW-1.
  assign expire = (MEMW > 0) && tick && (cnt == CW'(MEMW - 1));

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: hardwired control sequencer for instruction fetch and
// register-register ALU execution. Steps T0..T6 one state per clock.
//   clock, clear          clock; async active-low reset
//   ir[31:0]              IR contents, opcode at [31:27] (read only in T3..T6)
//   mem_ready             memory read data valid (used only in T1)
//   PCout..IRin           fetch strobes
//   Yin..LOin             execute strobes
//   Gra/Grb/Grc/Rin/Rout  register-select strobes for the external sel_encode
//   alu_op                ALU operation, opcode during T4, else 0
//   run                   0 once HALT has been decoded
//   illegal, mem_to       one-cycle pulses: bad opcode (T3) / T1 wait timeout
module alu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int MEMW = 4
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           IncPC,
  output logic           MARin,
  output logic           memRead,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           run,
  output logic           illegal,
  output logic           mem_to
);

  state_t         state, state_nxt;
  logic [OPW-1:0] opcode;
  logic           wait_exp;
  logic           mem_to_q;

  assign opcode = ir[31 -: OPW];

  // Register fields go to sel_encode, not used here.
  logic unused_ir;
  assign unused_ir = &{1'b0, ir[31-OPW:0]};

  alu_ctrl_seq_wait #(.MEMW(MEMW)) u_wait (
    .clock   (clock),
    .clear   (clear),
    .clr_cnt (state == S_T0),
    .tick    ((state == S_T1) && !mem_ready),
    .expire  (wait_exp)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_T0;
      mem_to_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Timeout is reported in the T0 cycle that follows the abandoned read,
      // keeping mem_to a registered output.
      mem_to_q <= wait_exp;
    end
  end

  assign mem_to = mem_to_q;

  always_comb begin
    state_nxt = state;
    PCout     = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    memRead   = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    alu_op    = '0;
    run       = 1'b1;
    illegal   = 1'b0;
    // Strobes are forced low while clear is held, not only after the next edge.
    if (clear) begin
      unique case (state)
        S_T0: begin
          PCout     = 1'b1;
          MARin     = 1'b1;
          IncPC     = 1'b1;
          state_nxt = S_T1;
        end
        S_T1: begin
          memRead = 1'b1;
          MDRin   = mem_ready;
          if (mem_ready)     state_nxt = S_T2;
          else if (wait_exp) state_nxt = S_T0;
        end
        S_T2: begin
          MDRout    = 1'b1;
          IRin      = 1'b1;
          state_nxt = S_T3;
        end
        S_T3: begin
          if (is_alu(opcode) || is_muldiv(opcode)) begin
            Grb       = 1'b1;
            Rout      = 1'b1;
            Yin       = 1'b1;
            state_nxt = S_T4;
          end else if (opcode == OP_NOP) begin
            state_nxt = S_T0;
          end else if (opcode == OP_HALT) begin
            state_nxt = S_HALTED;
          end else begin
            illegal   = 1'b1;
            state_nxt = S_T0;
          end
        end
        S_T4: begin
          Grc       = 1'b1;
          Rout      = 1'b1;
          Zin       = 1'b1;
          alu_op    = opcode;
          state_nxt = S_T5;
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (is_muldiv(opcode)) begin
            LOin      = 1'b1;
            state_nxt = S_T6;
          end else begin
            Gra       = 1'b1;
            Rin       = 1'b1;
            state_nxt = S_T0;
          end
        end
        S_T6: begin
          Zhighout  = 1'b1;
          HIin      = 1'b1;
          state_nxt = S_T0;
        end
        S_HALTED: begin
          run       = 1'b0;
          state_nxt = S_HALTED;
        end
        default: state_nxt = S_T0;
      endcase
    end
  end

endmodule
